calc1_top: RTL and testbench
============================

CALC1_TOP -- requirements
Module: calc1_top

Interface
REQ-001 SHALL: c_clk, in, 1, sole functional clock; all state updates on rising edge.
REQ-002 SHALL: reset, in, 7 ([1:7]), synchronous, active-high; block is in reset in any cycle where any bit is 1.
REQ-003 SHALL: a_clk, b_clk, in, 1 each, scan clocks kept for port compatibility, functionally ignored.
REQ-004 SHALL: error_found, in, 4 ([0:3]), debug input, functionally ignored.
REQ-005 SHALL: scan_in, in, 1, ignored; scan_out, out, 1, constant 0.
REQ-006 SHALL: reqN_cmd_in (N=1..4), in, 4 ([0:3]), command, 0 = no request.
REQ-007 SHALL: reqN_data_in, in, 32 ([0:31]), operand 1 in command cycle, operand 2 in following cycle.
REQ-008 SHALL: out_respN, out, 2 ([0:1]), response: 0 none, 1 success, 2 overflow/underflow/invalid, 3 reserved (never driven).
REQ-009 SHALL: out_dataN, out, 32 ([0:31]), result, valid only while out_respN != 0.
REQ-010 SHALL: all vectors are MSB-first, bit 0 is the MSB.

Function
REQ-011 SHALL: ports 1-4 operate fully independently and in parallel, with no shared arbitration.
REQ-012 SHALL: an idle port accepts a nonzero cmd in cycle T and latches cmd and data_in as op1; op2 = data_in at T+1.
REQ-013 SHALL: cmd is ignored at T+1 (operand cycle); the port is idle again and accepts a new command from T+2.
REQ-014 SHALL: the response is registered and appears in cycle T+3 for exactly one cycle; out_resp and out_data are 0 in every other cycle.
REQ-015 SHALL: cmd 1 add: 32-bit unsigned op1+op2; if there is a carry out, resp 2 with data 0, else resp 1 with the sum.
REQ-016 SHALL: cmd 2 subtract: op1-op2; if op2>op1, resp 2 with data 0, else resp 1 with the difference.
REQ-017 SHALL: cmd 5 shift left logical: op1 shifted by op2[27:31] (0-31), bits shifted out are discarded, resp 1.
REQ-018 SHALL: cmd 6 shift right logical: same shift-amount rule, zero fill, resp 1.
REQ-019 SHALL: cmds 3, 4 and 7-15 are invalid and give resp 2 with data 0, using the same timing as valid commands.
REQ-020 SHALL: back-to-back commands at T and T+2 produce responses at T+3 and T+5.

Reset
REQ-021 SHALL: in reset, all out_resp and out_data are 0 on the next edge, scan_out is 0, and all ports go idle.
REQ-022 SHALL: a command in flight when reset asserts is discarded and produces no response after reset releases.
REQ-023 SHALL: commands presented during reset are ignored; the first command is accepted in the first cycle after reset is deasserted.

Configuration
REQ-024 SHALL: macro CALC1_SHIFT_EN defined means cmds 5/6 behave per REQ-017/018.
REQ-025 SHALL: macro CALC1_SHIFT_EN undefined means no shifter logic is built and cmds 5/6 are treated as invalid (resp 2, data 0); add/sub are unaffected.

Structure
REQ-026 SHALL: package calc1_pkg holds the command encodings (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), the response encodings (NONE=0, OK=1, ERR=2, RSVD=3) and the data width constant 32.
REQ-027 SHALL: one sub-module calc1_port (capture FSM IDLE->OPND->EXEC->IDLE, ALU, response register) is instantiated four times in calc1_top.

Verification
REQ-028 SHALL: reset held 7 cycles, then port1 cmd 1 with data 0x80002345 followed by 0x00010000 -> out_resp1=1, out_data1=0x80012345 at T+3, other ports stay 0.
REQ-029 SHALL: add 0xFFFFFFFF + 0x00000001 -> resp 2, data 0; sub 0x5 - 0x3 -> resp 1, data 0x2; sub 0x3 - 0x5 -> resp 2, data 0.
REQ-030 SHALL: shl 0x00000001 by 0x00000021 (amount 1) -> resp 1, data 0x00000002; shr 0x80000000 by 31 -> resp 1, data 0x00000001.
REQ-031 SHALL: cmd 3 on port 4 -> resp 2, data 0 at T+3; with CALC1_SHIFT_EN undefined, cmd 5 -> resp 2.
REQ-032 SHALL: all four ports issue different commands in the same cycle -> four correct responses in the same cycle.
REQ-033 SHALL: reset asserted at T+1 of an add -> no response ever appears, and an add issued right after reset release completes normally.

Source files
------------

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared encodings for the calc1 four-port calculator.
//   Holds the command encodings, the response encodings and the data width.
//   Configuration macro: CALC1_SHIFT_EN (see calc1_port) enables the shifter.
package calc1_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [3:0] {
        CmdNop = 4'd0,
        CmdAdd = 4'd1,
        CmdSub = 4'd2,
        CmdShl = 4'd5,
        CmdShr = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RespNone = 2'd0,
        RespOk   = 2'd1,
        RespErr  = 2'd2,
        RespRsvd = 2'd3
    } resp_e;

endpackage

// File: rtl/calc1_port.sv
// calc1_port: one independent calculator port.
//   Capture FSM IDLE -> OPND -> EXEC -> IDLE. The command and operand 1 are taken in the
//   command cycle, operand 2 in the following cycle, and the registered response is shown
//   for one cycle, three cycles after the command.
//   Configuration macro: CALC1_SHIFT_EN builds the shifter (cmds 5/6); otherwise 5/6 are
//   reported as invalid.
// Ports:
//   clk     - functional clock, rising edge
//   rst     - synchronous active-high reset
//   cmd     - command, 0 = no request (MSB-first)
//   data_in - operand 1 in the command cycle, operand 2 in the next cycle
//   resp    - response: 0 none, 1 ok, 2 error
//   data    - result, zero whenever resp is 0
module calc1_port
    import calc1_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:3]           cmd,
    input  logic [0:DataWidth-1] data_in,
    output logic [0:1]           resp,
    output logic [0:DataWidth-1] data
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOpnd = 2'd1;
    localparam logic [1:0] StExec = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [0:3]           cmd_q;
    logic [0:DataWidth-1] op1_q;
    resp_e                res_resp_q;
    logic [0:DataWidth-1] res_data_q;

    resp_e                alu_resp;
    logic [0:DataWidth-1] alu_data;
    logic [0:DataWidth]   sum;      // bit 0 is the carry out
    logic                 accept;

`ifdef CALC1_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = data_in[DataWidth-5:DataWidth-1];
`endif

    // EXEC only waits for the result to be presented, so it may take a new command
    // exactly like IDLE; this is what allows back-to-back commands every two cycles.
    assign accept = (state_q != StOpnd) && (cmd != CmdNop);

    // Operand 2 is live on data_in while in OPND; the result is captured at the end of it.
    always_comb begin
        sum      = {1'b0, op1_q} + {1'b0, data_in};
        alu_resp = RespErr;
        alu_data = '0;
        case (cmd_q)
            CmdAdd: begin
                if (!sum[0]) begin
                    alu_resp = RespOk;
                    alu_data = sum[1:DataWidth];
                end
            end
            CmdSub: begin
                if (data_in <= op1_q) begin
                    alu_resp = RespOk;
                    alu_data = op1_q - data_in;
                end
            end
`ifdef CALC1_SHIFT_EN
            CmdShl: begin
                alu_resp = RespOk;
                alu_data = op1_q << shamt;
            end
            CmdShr: begin
                alu_resp = RespOk;
                alu_data = op1_q >> shamt;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle, StExec: state_d = accept ? StOpnd : StIdle;
            StOpnd:         state_d = StExec;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cmd_q      <= '0;
            op1_q      <= '0;
            res_resp_q <= RespNone;
            res_data_q <= '0;
            resp       <= '0;
            data       <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q <= cmd;
                op1_q <= data_in;
            end
            if (state_q == StOpnd) begin
                res_resp_q <= alu_resp;
                res_data_q <= alu_data;
            end
            // Outputs are nonzero for exactly the one cycle after EXEC.
            if (state_q == StExec) begin
                resp <= res_resp_q;
                data <= res_data_q;
            end else begin
                resp <= '0;
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/calc1_top.sv
// calc1_top: four independent calculator ports sharing only clock and reset.
//   Configuration macro: CALC1_SHIFT_EN enables shift commands in every port.
// Ports:
//   c_clk               - functional clock
//   a_clk, b_clk        - scan clocks, unused
//   reset [1:7]         - synchronous active-high; any set bit resets the block
//   error_found [0:3]   - debug input, unused
//   scan_in / scan_out  - scan chain stub, scan_out tied to 0
//   reqN_cmd_in [0:3]   - port N command
//   reqN_data_in [0:31] - port N operands
//   out_respN [0:1]     - port N response
//   out_dataN [0:31]    - port N result
module calc1_top
    import calc1_pkg::*;
(
    input  logic        c_clk,
    input  logic        a_clk,
    input  logic        b_clk,
    input  logic [1:7]  reset,
    input  logic [0:3]  error_found,
    input  logic        scan_in,
    output logic        scan_out,
    input  logic [0:3]  req1_cmd_in,
    input  logic [0:31] req1_data_in,
    input  logic [0:3]  req2_cmd_in,
    input  logic [0:31] req2_data_in,
    input  logic [0:3]  req3_cmd_in,
    input  logic [0:31] req3_data_in,
    input  logic [0:3]  req4_cmd_in,
    input  logic [0:31] req4_data_in,
    output logic [0:1]  out_resp1,
    output logic [0:31] out_data1,
    output logic [0:1]  out_resp2,
    output logic [0:31] out_data2,
    output logic [0:1]  out_resp3,
    output logic [0:31] out_data3,
    output logic [0:1]  out_resp4,
    output logic [0:31] out_data4
);

    logic rst;
    logic unused_inputs;

    assign rst           = |reset;
    assign scan_out      = 1'b0;
    assign unused_inputs = ^{a_clk, b_clk, error_found, scan_in};

    calc1_port u_port1 (
        .clk     (c_clk),
        .rst     (rst),
        .cmd     (req1_cmd_in),
        .data_in (req1_data_in),
        .resp    (out_resp1),
        .data    (out_data1)
    );

    calc1_port u_port2 (
        .clk     (c_clk),
        .rst     (rst),
        .cmd     (req2_cmd_in),
        .data_in (req2_data_in),
        .resp    (out_resp2),
        .data    (out_data2)
    );

    calc1_port u_port3 (
        .clk     (c_clk),
        .rst     (rst),
        .cmd     (req3_cmd_in),
        .data_in (req3_data_in),
        .resp    (out_resp3),
        .data    (out_data3)
    );

    calc1_port u_port4 (
        .clk     (c_clk),
        .rst     (rst),
        .cmd     (req4_cmd_in),
        .data_in (req4_data_in),
        .resp    (out_resp4),
        .data    (out_data4)
    );

endmodule

// File: tb/tb_calc1_top.sv
// tb_calc1_top: stimulus for the whole run is generated up front (directed prologue, then
// random traffic with occasional resets), a cycle-indexed model derives the expected
// response of every port in every cycle, and a negedge process compares the DUT to it.
module tb_calc1_top;

    localparam int NCYC = 400;

    logic        c_clk = 1'b0;
    logic        a_clk = 1'b0;
    logic        b_clk = 1'b0;
    logic [1:7]  reset = 7'h7f;
    logic [0:3]  error_found = 4'h0;
    logic        scan_in = 1'b0;
    logic        scan_out;
    logic [0:3]  i_cmd  [4];
    logic [0:31] i_data [4];
    logic [0:1]  o_resp [4];
    logic [0:31] o_data [4];

    logic [3:0]  st_cmd  [4][NCYC];
    logic [31:0] st_data [4][NCYC];
    logic [6:0]  st_rst  [NCYC];
    logic [1:0]  exp_resp [4][NCYC + 3];
    logic [31:0] exp_data [4][NCYC + 3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit run   = 1'b0;

    calc1_top dut (
        .c_clk        (c_clk),
        .a_clk        (a_clk),
        .b_clk        (b_clk),
        .reset        (reset),
        .error_found  (error_found),
        .scan_in      (scan_in),
        .scan_out     (scan_out),
        .req1_cmd_in  (i_cmd[0]),
        .req1_data_in (i_data[0]),
        .req2_cmd_in  (i_cmd[1]),
        .req2_data_in (i_data[1]),
        .req3_cmd_in  (i_cmd[2]),
        .req3_data_in (i_data[2]),
        .req4_cmd_in  (i_cmd[3]),
        .req4_data_in (i_data[3]),
        .out_resp1    (o_resp[0]),
        .out_data1    (o_data[0]),
        .out_resp2    (o_resp[1]),
        .out_data2    (o_data[1]),
        .out_resp3    (o_resp[2]),
        .out_data3    (o_data[2]),
        .out_resp4    (o_resp[3]),
        .out_data4    (o_data[3])
    );

    always #5 c_clk = ~c_clk;

    // Reference arithmetic straight from the command definitions.
    function automatic void calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 output logic [1:0] r, output logic [31:0] d);
        logic [63:0] s;
        r = 2'd2;
        d = 32'd0;
        s = {32'd0, a} + {32'd0, b};
        case (c)
            4'd1: if (s <= 64'hffff_ffff) begin r = 2'd1; d = s[31:0]; end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
`ifdef CALC1_SHIFT_EN
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
`endif
            default: ;
        endcase
    endfunction

    // Walk the stimulus: a port takes a command when out of reset and not in its operand
    // cycle; the answer lands three cycles later unless reset hits either following cycle.
    task automatic build_model();
        int          next_free;
        logic [1:0]  r;
        logic [31:0] d;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < NCYC + 3; c++) begin
                exp_resp[p][c] = 2'd0;
                exp_data[p][c] = 32'd0;
            end
            next_free = 0;
            for (int c = 0; c < NCYC - 2; c++) begin
                if (st_rst[c] != 7'd0) begin
                    next_free = c + 1;
                end else if (st_cmd[p][c] != 4'd0 && c >= next_free) begin
                    next_free = c + 2;
                    if (st_rst[c + 1] == 7'd0 && st_rst[c + 2] == 7'd0) begin
                        calc(st_cmd[p][c], st_data[p][c], st_data[p][c + 1], r, d);
                        exp_resp[p][c + 3] = r;
                        exp_data[p][c + 3] = d;
                    end
                end
            end
        end
    endtask

    task automatic pin(input string name, input int p, input int c,
                       input logic [1:0] r, input logic [31:0] d);
        n_vec++;
        if (exp_resp[p][c] !== r || exp_data[p][c] !== d) begin
            n_err++;
            $display("FAIL pin %s: model resp=%0d data=%h, required resp=%0d data=%h",
                     name, exp_resp[p][c], exp_data[p][c], r, d);
        end
    endtask

    task automatic put(input int p, input int c, input logic [3:0] cm, input logic [31:0] d);
        st_cmd[p][c]  = cm;
        st_data[p][c] = d;
    endtask

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'hffff_ffff;
            2:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [3:0] rand_cmd();
        case ($urandom_range(0, 9))
            5:       return 4'd1;
            6:       return 4'd2;
            7:       return 4'd5;
            8:       return 4'd6;
            9:       return 4'($urandom_range(0, 15));
            default: return 4'd0;
        endcase
    endfunction

    task automatic build_stimulus();
        int rst_left = 0;
        for (int c = 0; c < NCYC; c++) begin
            st_rst[c] = 7'd0;
            for (int p = 0; p < 4; p++) put(p, c, 4'd0, $urandom);
        end
        // Reset for 7 cycles with junk commands that must be ignored.
        for (int c = 0; c < 7; c++) begin
            st_rst[c] = (c == 0) ? 7'h7f : 7'(1 << $urandom_range(0, 6));
            for (int p = 0; p < 4; p++) put(p, c, 4'($urandom_range(1, 15)), $urandom);
        end
        put(0, 7, 4'd1, 32'h8000_2345);  put(0, 8, 4'd0, 32'h0001_0000);
        put(0, 10, 4'd1, 32'hffff_ffff); put(0, 11, 4'd0, 32'h1);
        put(1, 10, 4'd2, 32'h5);         put(1, 11, 4'd0, 32'h3);
        put(2, 10, 4'd2, 32'h3);         put(2, 11, 4'd0, 32'h5);
        put(3, 10, 4'd3, 32'h1234);      put(3, 11, 4'd0, 32'h1);
        put(0, 12, 4'd5, 32'h1);         put(0, 13, 4'd0, 32'h21);
        put(1, 12, 4'd6, 32'h8000_0000); put(1, 13, 4'd0, 32'd31);
        put(2, 12, 4'd1, 32'd7);         put(2, 13, 4'd2, 32'd8);  // cmd ignored in operand cycle
        put(2, 14, 4'd1, 32'd100);       put(2, 15, 4'd1, 32'd1);
        put(3, 12, 4'd5, 32'h3);         put(3, 13, 4'd0, 32'h4);
        put(0, 20, 4'd1, 32'd1);         put(0, 21, 4'd0, 32'd2);
        st_rst[21] = 7'h08;
        put(0, 22, 4'd1, 32'd10);        put(0, 23, 4'd0, 32'd20);
        for (int c = 30; c < NCYC - 6; c++) begin
            if (rst_left > 0) begin
                rst_left--;
                st_rst[c] = 7'($urandom_range(1, 127));
            end else if ($urandom_range(0, 49) == 0) begin
                rst_left = $urandom_range(0, 2);
                st_rst[c] = 7'($urandom_range(1, 127));
            end
            for (int p = 0; p < 4; p++) put(p, c, rand_cmd(), rand_data());
        end
    endtask

    always @(negedge c_clk) begin
        if (run && cyc >= 1) begin
            n_vec++;
            if (scan_out !== 1'b0) begin
                n_err++;
                $display("FAIL scan_out cyc %0d: got %b, required 0", cyc, scan_out);
            end
            for (int p = 0; p < 4; p++) begin
                n_vec++;
                if (o_resp[p] !== exp_resp[p][cyc] || o_data[p] !== exp_data[p][cyc]) begin
                    n_err++;
                    $display("FAIL port%0d cyc %0d: got resp=%0d data=%h, required resp=%0d data=%h",
                             p + 1, cyc, o_resp[p], o_data[p], exp_resp[p][cyc], exp_data[p][cyc]);
                end
            end
        end
    end

    initial begin
        for (int p = 0; p < 4; p++) begin
            i_cmd[p]  = 4'd0;
            i_data[p] = 32'd0;
        end
        build_stimulus();
        build_model();

        pin("add_basic", 0, 10, 2'd1, 32'h8001_2345);
        pin("add_idle_p2", 1, 10, 2'd0, 32'h0);
        pin("add_carry", 0, 13, 2'd2, 32'h0);
        pin("sub_ok", 1, 13, 2'd1, 32'h2);
        pin("sub_under", 2, 13, 2'd2, 32'h0);
        pin("cmd3_invalid", 3, 13, 2'd2, 32'h0);
`ifdef CALC1_SHIFT_EN
        pin("shl", 0, 15, 2'd1, 32'h2);
        pin("shr", 1, 15, 2'd1, 32'h1);
        pin("shl_p4", 3, 15, 2'd1, 32'h30);
`else
        pin("shl_off", 0, 15, 2'd2, 32'h0);
        pin("shr_off", 1, 15, 2'd2, 32'h0);
        pin("shl_p4_off", 3, 15, 2'd2, 32'h0);
`endif
        pin("b2b_first", 2, 15, 2'd1, 32'd15);
        pin("b2b_second", 2, 17, 2'd1, 32'd101);
        pin("reset_kill", 0, 23, 2'd0, 32'h0);
        pin("after_reset", 0, 25, 2'd1, 32'd30);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge c_clk);
            #1;
            reset = st_rst[c];
            error_found = 4'($urandom);
            scan_in = 1'($urandom);
            for (int p = 0; p < 4; p++) begin
                i_cmd[p]  = st_cmd[p][c];
                i_data[p] = st_data[p][c];
            end
            cyc = c;
            run = 1'b1;
        end
        @(posedge c_clk);
        #1;
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
